// File: rtl/modbus_rx_pkg.sv
// Shared types and constants for the Modbus RTU receive frame controller.
package modbus_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        CHECK,
        WRITE,
        WAIT_GAP
    } state_t;

    localparam logic [2:0] ERR_ADDR    = 3'd1;
    localparam logic [2:0] ERR_FUNC    = 3'd2;
    localparam logic [2:0] ERR_COUNT   = 3'd3;
    localparam logic [2:0] ERR_CRC     = 3'd4;
    localparam logic [2:0] ERR_OVERRUN = 3'd5;
    localparam logic [2:0] ERR_SHORT   = 3'd6;

    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    localparam logic [15:0] CRC_POLY = 16'hA001;

endpackage

// File: rtl/modbus_crc16_serial.sv
// Bit-serial Modbus CRC-16 (reflected 0xA001): one byte is absorbed over 8 cycles.
module modbus_crc16_serial
    import modbus_rx_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        init,
    input  logic [7:0]  data_byte,
    output logic        busy,
    output logic [15:0] crc
);

    logic [3:0] bit_cnt;

    // The byte is XORed into the low half on load; the 8 shifts then follow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc     <= CRC_INIT;
            bit_cnt <= 4'd0;
        end else if (start) begin
            crc     <= (init ? CRC_INIT : crc) ^ {8'h00, data_byte};
            bit_cnt <= 4'd8;
        end else if (bit_cnt != 4'd0) begin
            crc     <= crc[0] ? ((crc >> 1) ^ CRC_POLY) : (crc >> 1);
            bit_cnt <= bit_cnt - 4'd1;
        end
    end

    assign busy = (bit_cnt != 4'd0);

endmodule

// File: rtl/modbus_rx_frame_ctrl.sv
// Modbus RTU receive framing, filtering and all-or-nothing register commit.
// Define MODBUS_RX_STATS_EN to add the ok_cnt/err_cnt frame counters.
module modbus_rx_frame_ctrl
    import modbus_rx_pkg::*;
#(
    parameter logic [7:0] SLAVE_ADDR = 8'h02,
    parameter logic [7:0] FUNC_CODE  = 8'h03,
    parameter int         NREG       = 10,
    parameter int         GAP_CYCLES = 15200
) (
    input  logic        clk,
    input  logic        rst_n,
    // Handshake: byte_valid is a one-cycle strobe with no back-pressure; a byte
    // that cannot be taken (CRC busy, CHECK, WRITE) is flagged as an overrun.
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        reg_we,
    output logic [3:0]  reg_idx,
    output logic [15:0] reg_data,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [2:0]  err_code,
    output logic        busy,
`ifdef MODBUS_RX_STATS_EN
    output logic [15:0] ok_cnt,
    output logic [15:0] err_cnt,
`endif
    output state_t      dbg_state
);

    localparam int FLEN   = 2 * NREG + 5;
    localparam int BCNT_W = $clog2(FLEN + 1);
    localparam int BUF_W  = $clog2(2 * NREG);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
    localparam logic [BCNT_W-1:0] FLEN_C     = BCNT_W'(FLEN);
    localparam logic [7:0]        BYTE_COUNT = 8'(2 * NREG);
    localparam logic [3:0]        LAST_IDX   = 4'(NREG - 1);

    state_t              state, state_n;
    logic [GAP_W-1:0]    gap_cnt;
    logic                gap_done;
    logic [BCNT_W-1:0]   bcnt;
    logic [7:0]          data_buf [2*NREG];
    logic                crc_start, crc_init, crc_busy;
    logic [15:0]         crc_val;
    logic                take, err_n, wr_n, ok_n;
    logic [2:0]          code_n;
    logic [3:0]          widx_n;
    logic [BUF_W-1:0]    rd_hi, rd_lo, wr_pos;

    modbus_crc16_serial u_crc (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (crc_start),
        .init      (crc_init),
        .data_byte (byte_data),
        .busy      (crc_busy),
        .crc       (crc_val)
    );

    assign gap_done  = (gap_cnt == GAP_W'(GAP_CYCLES));
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n   = state;
        crc_start = 1'b0;
        crc_init  = 1'b0;
        take      = 1'b0;
        err_n     = 1'b0;
        code_n    = err_code;
        wr_n      = 1'b0;
        ok_n      = 1'b0;
        widx_n    = reg_idx;
        case (state)
            IDLE: if (byte_valid) begin
                crc_start = 1'b1;
                crc_init  = 1'b1;
                take      = 1'b1;
                if (byte_data != SLAVE_ADDR) begin
                    err_n = 1'b1; code_n = ERR_ADDR; state_n = WAIT_GAP;
                end else begin
                    state_n = RECV;
                end
            end
            RECV: if (byte_valid) begin
                if (crc_busy || bcnt == FLEN_C) begin
                    err_n = 1'b1; code_n = ERR_OVERRUN; state_n = WAIT_GAP;
                end else begin
                    crc_start = 1'b1;
                    take      = 1'b1;
                    if (bcnt == BCNT_W'(1) && byte_data != FUNC_CODE) begin
                        err_n = 1'b1; code_n = ERR_FUNC; state_n = WAIT_GAP;
                    end else if (bcnt == BCNT_W'(2) && byte_data != BYTE_COUNT) begin
                        err_n = 1'b1; code_n = ERR_COUNT; state_n = WAIT_GAP;
                    end
                end
            end else if (bcnt == FLEN_C) begin
                if (!crc_busy) state_n = CHECK;
            end else if (gap_done) begin
                err_n = 1'b1; code_n = ERR_SHORT; state_n = IDLE;
            end
            CHECK: if (byte_valid) begin
                err_n = 1'b1; code_n = ERR_OVERRUN; state_n = WAIT_GAP;
            end else if (crc_val == 16'h0000) begin
                state_n = WRITE; wr_n = 1'b1; widx_n = 4'd0;
            end else begin
                err_n = 1'b1; code_n = ERR_CRC; state_n = WAIT_GAP;
            end
            WRITE: if (byte_valid) begin
                err_n = 1'b1; code_n = ERR_OVERRUN; state_n = WAIT_GAP;
            end else if (reg_idx == LAST_IDX) begin
                ok_n = 1'b1; state_n = WAIT_GAP;
            end else begin
                wr_n = 1'b1; widx_n = reg_idx + 4'd1;
            end
            WAIT_GAP: if (!byte_valid && gap_done) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign rd_hi  = BUF_W'(2 * widx_n);
    assign rd_lo  = rd_hi + BUF_W'(1);
    assign wr_pos = BUF_W'(bcnt - BCNT_W'(3));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt   <= GAP_W'(GAP_CYCLES);
            bcnt      <= '0;
            reg_we    <= 1'b0;
            reg_idx   <= 4'd0;
            reg_data  <= 16'h0000;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= 3'd0;
        end else begin
            if (byte_valid)     gap_cnt <= '0;
            else if (!gap_done) gap_cnt <= gap_cnt + GAP_W'(1);
            if (take) bcnt <= (state == IDLE) ? BCNT_W'(1) : bcnt + BCNT_W'(1);
            reg_we    <= wr_n;
            frame_ok  <= ok_n;
            frame_err <= err_n;
            err_code  <= code_n;
            if (wr_n) begin
                reg_idx  <= widx_n;
                reg_data <= {data_buf[rd_hi], data_buf[rd_lo]};
            end
        end
    end

    // Payload bytes k = 3 .. 2*NREG+2 land in data_buf[k-3].
    always_ff @(posedge clk) begin
        if (take && state == RECV && bcnt >= BCNT_W'(3) && bcnt < BCNT_W'(FLEN - 2))
            data_buf[wr_pos] <= byte_data;
    end

`ifdef MODBUS_RX_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ok_cnt  <= 16'h0000;
            err_cnt <= 16'h0000;
        end else begin
            if (ok_n)  ok_cnt  <= ok_cnt + 16'h0001;
            if (err_n) err_cnt <= err_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_modbus_rx_frame_ctrl.sv
// Self-checking bench for modbus_rx_frame_ctrl (MODBUS_RX_STATS_EN optional).
module tb_modbus_rx_frame_ctrl;
    import modbus_rx_pkg::*;

    localparam int NREG = 10;
    localparam int G    = 300;
    localparam int FLEN = 2 * NREG + 5;

    logic        clk = 1'b0, rst_n = 1'b0, byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        reg_we, frame_ok, frame_err, busy;
    logic [3:0]  reg_idx;
    logic [15:0] reg_data;
    logic [2:0]  err_code;
    state_t      dbg_state;
`ifdef MODBUS_RX_STATS_EN
    logic [15:0] ok_cnt, err_cnt;
`endif

    modbus_rx_frame_ctrl #(.NREG(NREG), .GAP_CYCLES(G)) dut (
        .clk(clk), .rst_n(rst_n), .byte_valid(byte_valid), .byte_data(byte_data),
        .reg_we(reg_we), .reg_idx(reg_idx), .reg_data(reg_data),
        .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code), .busy(busy),
`ifdef MODBUS_RX_STATS_EN
        .ok_cnt(ok_cnt), .err_cnt(err_cnt),
`endif
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0, n_pass = 0;
    logic [7:0]  frame_q[$];
    int          byte_t[$];
    logic [19:0] exp_q[$];

    // monitor: only appends / accumulates
    logic [19:0] wr_q[$];
    int          wr_cyc[$];
    int          ok_tot = 0, err_tot = 0, ok_cyc = 0, err_cyc = 0;
    logic [2:0]  err_seen = 3'd0;
    always @(negedge clk) begin
        if (reg_we) begin wr_q.push_back({reg_idx, reg_data}); wr_cyc.push_back(cyc); end
        if (frame_ok) begin ok_tot++; ok_cyc = cyc; end
        if (frame_err) begin err_tot++; err_cyc = cyc; err_seen = err_code; end
    end

    // reference model
    function automatic logic [15:0] crc16(input logic [7:0] q[$]);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (q[i]) begin
            c = c ^ {8'h00, q[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    function automatic int model_err(input logic [7:0] q[$]);
        if (q.size() > 0 && q[0] != 8'h02) return 1;
        if (q.size() > 1 && q[1] != 8'h03) return 2;
        if (q.size() > 2 && q[2] != 8'(2 * NREG)) return 3;
        if (q.size() < FLEN) return 6;
        if (crc16(q) != 16'h0000) return 4;
        return 0;
    endfunction

    // driver tasks
    task automatic build_frame(input int kind, input bit fixed, input int trunc);
        logic [15:0] c;
        frame_q.delete();
        frame_q.push_back(8'h02); frame_q.push_back(8'h03); frame_q.push_back(8'(2 * NREG));
        for (int i = 0; i < NREG; i++) begin
            if (fixed) begin
                frame_q.push_back(8'h00); frame_q.push_back(8'(i + 1));
            end else begin
                frame_q.push_back(8'($urandom_range(0, 255)));
                frame_q.push_back(8'($urandom_range(0, 255)));
            end
        end
        c = crc16(frame_q);
        frame_q.push_back(c[7:0]); frame_q.push_back(c[15:8]);
        case (kind)
            1: frame_q[FLEN-1] = frame_q[FLEN-1] ^ 8'h01;
            2: frame_q[0] = 8'($urandom_range(3, 255));
            3: frame_q[1] = 8'($urandom_range(4, 255));
            4: frame_q[2] = 8'($urandom_range(21, 255));
            5: while (frame_q.size() > trunc) void'(frame_q.pop_back());
            default: ;
        endcase
    endtask

    task automatic send_frame(input int smin, input int smax, input int ovr_k, input int ovr_gap);
        int sp;
        byte_t.delete();
        foreach (frame_q[i]) begin
            if (i > 0) begin
                sp = (i == ovr_k) ? ovr_gap : int'($urandom_range(smin, smax));
                repeat (sp - 1) @(negedge clk);
            end
            byte_valid = 1'b1; byte_data = frame_q[i];
            @(negedge clk);
            byte_valid = 1'b0;
            byte_t.push_back(cyc);
        end
    endtask

    task automatic run_frame(input string name, input int smin, input int smax,
                             input int ovr_k, input int ovr_gap);
        int e, wb, ob, eb, tl, lo, hi;
        logic [2:0] code_before;
        logic [19:0] exp_w;
        e = (ovr_k >= 0) ? 5 : model_err(frame_q);
        wb = wr_q.size(); ob = ok_tot; eb = err_tot; code_before = err_code;
        exp_q.delete();
        if (e == 0)
            for (int i = 0; i < NREG; i++) exp_q.push_back({4'(i), frame_q[3+2*i], frame_q[4+2*i]});
        send_frame(smin, smax, ovr_k, ovr_gap);
        tl = byte_t[byte_t.size()-1];
        repeat (G + 20) @(negedge clk);

        n_checks++;
        if (err_tot - eb !== ((e != 0) ? 1 : 0)) $display("FAIL %s err_pulses: got %0d want %0d", name, err_tot - eb, (e != 0) ? 1 : 0);
        else n_pass++;
        n_checks++;
        if (ok_tot - ob !== ((e == 0) ? 1 : 0)) $display("FAIL %s ok_pulses: got %0d want %0d", name, ok_tot - ob, (e == 0) ? 1 : 0);
        else n_pass++;
        n_checks++;
        if (wr_q.size() - wb !== ((e == 0) ? NREG : 0)) $display("FAIL %s write_count: got %0d want %0d", name, wr_q.size() - wb, (e == 0) ? NREG : 0);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0 || dbg_state !== IDLE) $display("FAIL %s idle_after_gap: busy %0b state %0d want 0/IDLE", name, busy, dbg_state);
        else n_pass++;

        if (e != 0 && err_tot - eb == 1) begin
            case (e)
                1, 2, 3: begin lo = byte_t[e-1]; hi = lo + 1; end
                5:       begin lo = byte_t[ovr_k]; hi = lo + 1; end
                4:       begin lo = tl + 10; hi = lo; end
                default: begin lo = tl + G; hi = tl + G + 2; end
            endcase
            n_checks++;
            if (err_seen !== 3'(e)) $display("FAIL %s err_code: got %0d want %0d", name, err_seen, e);
            else n_pass++;
            n_checks++;
            if (err_cyc < lo || err_cyc > hi) $display("FAIL %s err_time: got %0d want %0d..%0d", name, err_cyc, lo, hi);
            else n_pass++;
        end
        if (e == 0 && wr_q.size() - wb == NREG) begin
            for (int i = 0; i < NREG; i++) begin
                exp_w = exp_q.pop_front();
                n_checks++;
                if (wr_q[wb+i] !== exp_w) $display("FAIL %s write[%0d]: got %h want %h", name, i, wr_q[wb+i], exp_w);
                else n_pass++;
            end
            n_checks++;
            if (wr_cyc[wb] !== tl + 10 || wr_cyc[wb+NREG-1] !== tl + 9 + NREG)
                $display("FAIL %s write_time: got %0d..%0d want %0d..%0d", name, wr_cyc[wb], wr_cyc[wb+NREG-1], tl + 10, tl + 9 + NREG);
            else n_pass++;
            n_checks++;
            if (ok_cyc !== tl + 10 + NREG) $display("FAIL %s ok_time: got %0d want %0d", name, ok_cyc, tl + 10 + NREG);
            else n_pass++;
            n_checks++;
            if (err_code !== code_before) $display("FAIL %s err_code_hold: got %0d want %0d", name, err_code, code_before);
            else n_pass++;
        end
    endtask

    // scenarios
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({reg_we, reg_idx, reg_data, frame_ok, frame_err, err_code, busy} !== 26'd0 || dbg_state !== IDLE)
            $display("FAIL reset_outputs: got we%0b idx%0d data%h ok%0b err%0b code%0d busy%0b want all 0",
                     reg_we, reg_idx, reg_data, frame_ok, frame_err, err_code, busy);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_good_frame();
        build_frame(0, 1'b1, 0);
        run_frame("good_fixed", 20, 20, -1, 0);
    endtask

    task automatic test_crc_error();
        build_frame(1, 1'b1, 0);
        run_frame("crc_error", 20, 20, -1, 0);
    endtask

    task automatic test_bad_addr();
        build_frame(0, 1'b1, 0);
        frame_q[0] = 8'h05;
        run_frame("bad_addr", 20, 20, -1, 0);
        build_frame(0, 1'b1, 0);
        run_frame("good_after_addr", 20, 20, -1, 0);
    endtask

    task automatic test_short();
        build_frame(5, 1'b1, 12);
        run_frame("short", 20, 20, -1, 0);
    endtask

    task automatic test_overrun();
        build_frame(0, 1'b1, 0);
        run_frame("overrun_4", 20, 20, 1, 4);
        build_frame(0, 1'b0, 0);
        run_frame("overrun_8", 12, 20, int'($urandom_range(1, FLEN - 1)), 8);
    endtask

    task automatic test_min_spacing();
        build_frame(0, 1'b0, 0);
        run_frame("min_spacing_9", 9, 9, -1, 0);
    endtask

    task automatic test_reset_mid_write();
        int wb, ob, eb, tl;
        build_frame(0, 1'b1, 0);
        wb = wr_q.size(); ob = ok_tot; eb = err_tot;
        send_frame(20, 20, -1, 0);
        tl = byte_t[byte_t.size()-1];
        while (cyc < tl + 12) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({reg_we, reg_idx, reg_data, frame_ok, frame_err, err_code, busy} !== 26'd0 || dbg_state !== IDLE)
            $display("FAIL reset_mid_write_outputs: got we%0b idx%0d data%h busy%0b want all 0", reg_we, reg_idx, reg_data, busy);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        n_checks++;
        if (wr_q.size() - wb !== 3 || ok_tot - ob !== 0 || err_tot - eb !== 0)
            $display("FAIL reset_mid_write_activity: got writes %0d ok %0d err %0d want 3/0/0", wr_q.size() - wb, ok_tot - ob, err_tot - eb);
        else n_pass++;
        build_frame(0, 1'b1, 0);
        run_frame("good_after_reset", 20, 20, -1, 0);
`ifdef MODBUS_RX_STATS_EN
        n_checks++;
        if (ok_cnt !== 16'd1 || err_cnt !== 16'd0) $display("FAIL stats_after_reset: got ok %0d err %0d want 1/0", ok_cnt, err_cnt);
        else n_pass++;
`endif
    endtask

    task automatic test_random();
        int kind;
        for (int n = 0; n < 10; n++) begin
            kind = int'($urandom_range(0, 5));
            build_frame(kind, 1'b0, int'($urandom_range(1, FLEN - 1)));
            run_frame($sformatf("random_%0d_kind%0d", n, kind), 9, 25, -1, 0);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_good_frame();
        test_crc_error();
        test_bad_addr();
        test_short();
        test_overrun();
        test_min_spacing();
        test_reset_mid_write();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
